// File: rtl/audio_dac_serializer_if.sv
// Streaming frame handshake into the DAC serializer.
interface audio_dac_serializer_if #(
    parameter int W = 32
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/audio_dac_serializer.sv
// Codec DAC serializer: frame FIFO, bclk/lrck-slaved MSB-first shifter.
// Optional attenuation port att_shift when AUD_SER_ATTEN_EN is defined.
module audio_dac_serializer #(
    parameter int DATA_W     = 16,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int MODE       = 0
) (
    input  logic                             clk_clk,
    input  logic                             reset_reset,
    input  logic                             enable,
`ifdef AUD_SER_ATTEN_EN
    input  logic [3:0]                       att_shift,
`endif
    audio_dac_serializer_if.slave            snk,
    input  logic                             bclk_export,
    input  logic                             daclrck_export,
    output logic                             dacdat_export,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic [15:0]                      underrun_cnt
);

    localparam int W   = CHANNELS * DATA_W;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = $clog2(FIFO_DEPTH + 1);
    localparam int IW  = 6;
    localparam int OFF = (MODE == 0) ? 1 : 0;
    localparam logic LEFT_LVL = (MODE == 0) ? 1'b0 : 1'b1;

    typedef enum logic [1:0] {
        UNLOCKED,
        WAIT_LEFT,
        LEFT,
        RIGHT
    } state_t;

    state_t st, st_nxt;

    logic [1:0]    bclk_sync;
    logic [1:0]    lrck_sync;
    logic          bclk_q;
    logic          lrck_prev;
    logic          prev_vld;
    logic          lrck_now;
    logic          fall_tick;
    logic          lr_edge;
    logic          into_left;

    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic [W-1:0]  rd_word;
    logic [W-1:0]  load_word;
    logic [W-1:0]  hold;
    logic [W-1:0]  hold_nxt;
    logic [15:0]   und;

    logic [IW-1:0] bit_idx;
    logic [IW-1:0] idx_nxt;
    logic [DATA_W-1:0] left_w;
    logic [DATA_W-1:0] right_w;
    logic [DATA_W-1:0] slot_w;
    logic          bit_nxt;
    logic          dacdat;

    // Codec clocks are asynchronous: two-stage synchronisers, edge on synced copies
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            bclk_q    <= 1'b0;
            lrck_prev <= 1'b0;
            prev_vld  <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], bclk_export};
            lrck_sync <= {lrck_sync[0], daclrck_export};
            bclk_q    <= bclk_sync[1];
            if (fall_tick) begin
                lrck_prev <= lrck_sync[1];
                prev_vld  <= 1'b1;
            end
        end
    end

    assign lrck_now  = lrck_sync[1];
    assign fall_tick = bclk_q & ~bclk_sync[1];
    assign lr_edge   = fall_tick && prev_vld && (lrck_now != lrck_prev);
    assign into_left = lr_edge && (lrck_now == LEFT_LVL);

    assign full      = (level == LW'(FIFO_DEPTH));
    assign empty     = (level == '0);
    assign snk.ready = !full && !reset_reset;
    assign push      = snk.valid && snk.ready;
    assign pop       = into_left && enable && !empty;

    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem[wr_ptr] <= snk.data;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign rd_word = mem[rd_ptr];

    always_comb begin
        load_word = '0;
        if (enable && !empty) begin
            for (int c = 0; c < CHANNELS; c++) begin
`ifdef AUD_SER_ATTEN_EN
                load_word[c*DATA_W +: DATA_W] =
                    DATA_W'($signed(rd_word[c*DATA_W +: DATA_W]) >>> att_shift);
`else
                load_word[c*DATA_W +: DATA_W] = rd_word[c*DATA_W +: DATA_W];
`endif
            end
        end
    end

    // Silence replaces a frame only when playback wanted one and none was there
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            hold <= '0;
            und  <= '0;
        end else if (into_left) begin
            hold <= load_word;
            if (enable && empty && und != 16'hFFFF) begin
                und <= und + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            st <= UNLOCKED;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt = st;
        if (lr_edge) begin
            if (into_left) begin
                st_nxt = LEFT;
            end else begin
                case (st)
                    UNLOCKED:  st_nxt = WAIT_LEFT;
                    WAIT_LEFT: st_nxt = WAIT_LEFT;
                    LEFT:      st_nxt = RIGHT;
                    default:   st_nxt = st;
                endcase
            end
        end
    end

    always_comb begin
        if (lr_edge) begin
            idx_nxt = '0;
        end else if (bit_idx == '1) begin
            idx_nxt = bit_idx;
        end else begin
            idx_nxt = bit_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            bit_idx <= '0;
        end else if (fall_tick) begin
            bit_idx <= idx_nxt;
        end
    end

    // Look ahead at the word being loaded so LJ can drive its MSB on the boundary
    always_comb begin
        hold_nxt = into_left ? load_word : hold;
        left_w   = hold_nxt[(CHANNELS-1)*DATA_W +: DATA_W];
        right_w  = hold_nxt[0 +: DATA_W];
        slot_w   = (st_nxt == RIGHT) ? right_w : left_w;
        bit_nxt  = 1'b0;
        if (st_nxt == LEFT || st_nxt == RIGHT) begin
            for (int k = 0; k < DATA_W; k++) begin
                if (idx_nxt == IW'(k + OFF)) begin
                    bit_nxt = slot_w[DATA_W-1-k];
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            dacdat <= 1'b0;
        end else if (fall_tick) begin
            dacdat <= bit_nxt;
        end
    end

    assign dacdat_export = dacdat;
    assign fifo_level    = level;
    assign underrun_cnt  = und;

endmodule
